// File: rtl/smem_fifo_pkg.sv
// Shared definitions for the SMEM multi-write FIFO: default sizes, width helpers
// and the default entry type.
package smem_fifo_pkg;

  localparam int MWF_DATA_WIDTH_DEF = 65;
  localparam int MWF_WR_PORTS_DEF   = 2;

  typedef logic [MWF_DATA_WIDTH_DEF-1:0] smem_entry_t;

  function automatic int mwf_clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  // Width of a lane count that can express 0..wr_ports.
  function automatic int mwf_wcnt_w(input int wr_ports);
    return mwf_clog2(wr_ports + 1);
  endfunction

endpackage

// File: rtl/multi_write_sync_fifo_if.sv
// Producer/consumer bundle of the multi-write FIFO; master is the producer and
// consumer side, slave is the FIFO.
interface multi_write_sync_fifo_if #(
  parameter int DATA_WIDTH    = smem_fifo_pkg::MWF_DATA_WIDTH_DEF,
  parameter int ADDRESS_WIDTH = 4,
  parameter int WR_PORTS      = smem_fifo_pkg::MWF_WR_PORTS_DEF
);
  import smem_fifo_pkg::*;

  localparam int WCNT_W = mwf_wcnt_w(WR_PORTS);

  // Handshake: a write of WriteCnt_in lanes takes effect only when the count fits the
  // free slots at the start of the cycle (Full_out is the registered hint); a pop is
  // taken when ReadEn_in is high and the FIFO is not empty, and its entry appears one
  // cycle later qualified by Data_valid.
  logic [WR_PORTS*DATA_WIDTH-1:0] Data_in;
  logic [WCNT_W-1:0]              WriteCnt_in;
  logic                           Full_out;
  logic                           Almost_full_out;
  logic [ADDRESS_WIDTH:0]         Free_out;
  logic                           ReadEn_in;
  logic                           Empty_out;
  logic [DATA_WIDTH-1:0]          Data_out;
  logic                           Data_valid;
  logic                           Overflow_out;
  logic                           Underflow_out;

  modport master (
    output Data_in, WriteCnt_in, ReadEn_in,
    input  Full_out, Almost_full_out, Free_out, Empty_out,
    input  Data_out, Data_valid, Overflow_out, Underflow_out
  );

  modport slave (
    input  Data_in, WriteCnt_in, ReadEn_in,
    output Full_out, Almost_full_out, Free_out, Empty_out,
    output Data_out, Data_valid, Overflow_out, Underflow_out
  );

endinterface

// File: rtl/fifo_occupancy_ctr.sv
// Occupancy tracking for the multi-write FIFO: accept/pop decisions, count register and
// registered status flags. Sticky error flags exist only with MWFIFO_ERR_FLAGS_EN.
module fifo_occupancy_ctr
  import smem_fifo_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 4,
  parameter int WR_PORTS      = 2,
  parameter int AFULL_MARGIN  = 2,
  parameter int WCNT_W        = mwf_wcnt_w(WR_PORTS)
) (
  input  logic                   Clk,
  input  logic                   Clear_in,
  input  logic [WCNT_W-1:0]      wcnt,
  input  logic                   rd_en,
  output logic                   accept,
  output logic                   pop,
  output logic                   full,
  output logic                   afull,
  output logic                   empty,
  output logic [ADDRESS_WIDTH:0] free,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int CW    = ADDRESS_WIDTH + 1;
  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [CW-1:0]     DEPTH_C   = CW'(DEPTH);
  localparam logic [WCNT_W-1:0] MAX_WCNT  = WCNT_W'(WR_PORTS);
  localparam logic [CW-1:0]     PORTS_C   = CW'(WR_PORTS);
  localparam logic [CW-1:0]     MARGIN_C  = CW'(AFULL_MARGIN);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_next;
  logic [CW-1:0] free_now;
  logic [CW-1:0] free_next;
  logic [CW-1:0] wcnt_ext;

  // Decisions use only start-of-cycle occupancy: a same-cycle pop never makes room.
  always_comb begin
    free_now   = DEPTH_C - count_q;
    wcnt_ext   = CW'(wcnt);
    accept     = !Clear_in && (wcnt <= MAX_WCNT) && (wcnt_ext <= free_now);
    pop        = !Clear_in && rd_en && (count_q != '0);
    count_next = count_q;
    if (accept) count_next = count_next + wcnt_ext;
    if (pop)    count_next = count_next - CW'(1);
    free_next  = DEPTH_C - count_next;
  end

  always_ff @(posedge Clk) begin
    if (Clear_in) begin
      count_q <= '0;
      full    <= 1'b0;
      afull   <= (DEPTH <= AFULL_MARGIN);
      empty   <= 1'b1;
      free    <= DEPTH_C;
    end else begin
      count_q <= count_next;
      full    <= (free_next < PORTS_C);
      afull   <= (free_next <= MARGIN_C);
      empty   <= (count_next == '0);
      free    <= free_next;
    end
  end

`ifdef MWFIFO_ERR_FLAGS_EN
  always_ff @(posedge Clk) begin
    if (Clear_in) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (!accept && (wcnt != '0)) overflow <= 1'b1;
      if (rd_en && (count_q == '0)) underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: rtl/multi_write_sync_fifo.sv
// Single-clock FIFO taking 0..WR_PORTS entries per cycle and returning one per pop.
// Define MWFIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module multi_write_sync_fifo
  import smem_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = MWF_DATA_WIDTH_DEF,
  parameter int ADDRESS_WIDTH = 4,
  parameter int WR_PORTS      = MWF_WR_PORTS_DEF,
  parameter int AFULL_MARGIN  = 2
) (
  input logic                   Clk,
  input logic                   Clear_in,
  multi_write_sync_fifo_if.slave bus
);

  localparam int DEPTH  = 1 << ADDRESS_WIDTH;
  localparam int WCNT_W = mwf_wcnt_w(WR_PORTS);

  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH-1:0] rd_ptr;
  logic                     accept;
  logic                     pop;
  logic [ADDRESS_WIDTH-1:0] lane_addr [WR_PORTS];

  (* ramstyle = "logic" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  fifo_occupancy_ctr #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .WR_PORTS      (WR_PORTS),
    .AFULL_MARGIN  (AFULL_MARGIN),
    .WCNT_W        (WCNT_W)
  ) u_occ (
    .Clk       (Clk),
    .Clear_in  (Clear_in),
    .wcnt      (bus.WriteCnt_in),
    .rd_en     (bus.ReadEn_in),
    .accept    (accept),
    .pop       (pop),
    .full      (bus.Full_out),
    .afull     (bus.Almost_full_out),
    .empty     (bus.Empty_out),
    .free      (bus.Free_out),
    .overflow  (bus.Overflow_out),
    .underflow (bus.Underflow_out)
  );

  // Lane addresses wrap at DEPTH by truncation, so a split write keeps lane order.
  always_comb begin
    for (int i = 0; i < WR_PORTS; i++) begin
      lane_addr[i] = wr_ptr + ADDRESS_WIDTH'(i);
    end
  end

  always_ff @(posedge Clk) begin
    if (accept) begin
      for (int i = 0; i < WR_PORTS; i++) begin
        if (i < int'(bus.WriteCnt_in)) begin
          mem[lane_addr[i]] <= bus.Data_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Clear_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + ADDRESS_WIDTH'(bus.WriteCnt_in);
      if (pop)    rd_ptr <= rd_ptr + ADDRESS_WIDTH'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Clear_in) begin
      bus.Data_out   <= '0;
      bus.Data_valid <= 1'b0;
    end else begin
      bus.Data_valid <= pop;
      if (pop) bus.Data_out <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_multi_write_sync_fifo.sv
// Directed bench for multi_write_sync_fifo at 8-bit entries, depth 8, two write lanes.
module tb_multi_write_sync_fifo;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int WP = 2;
  localparam int AM = 2;

`ifdef MWFIFO_ERR_FLAGS_EN
  localparam logic FLAGS_ON = 1'b1;
`else
  localparam logic FLAGS_ON = 1'b0;
`endif

  // clock / reset
  logic Clk = 1'b0;
  logic Clear_in;
  always #5 Clk = ~Clk;

  multi_write_sync_fifo_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .WR_PORTS(WP)) bus ();

  multi_write_sync_fifo #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .WR_PORTS      (WP),
    .AFULL_MARGIN  (AM)
  ) dut (
    .Clk      (Clk),
    .Clear_in (Clear_in),
    .bus      (bus)
  );

  // scoreboard
  logic [DW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: apply inputs at negedge, sample #1 after the following posedge
  task automatic cycle(input logic [1:0] wcnt, input logic [DW-1:0] d1, input logic [DW-1:0] d0,
                       input logic rd);
    @(negedge Clk);
    bus.WriteCnt_in = wcnt;
    bus.Data_in     = {d1, d0};
    bus.ReadEn_in   = rd;
    @(posedge Clk);
    #1;
  endtask

  task automatic wr2(input logic [DW-1:0] d1, input logic [DW-1:0] d0);
    cycle(2'd2, d1, d0, 1'b0);
    exp_q.push_back(d0);
    exp_q.push_back(d1);
  endtask

  task automatic status(input string tag, input int free, input logic full, input logic afull,
                        input logic empty);
    chk({tag, "_free"},  32'(bus.Free_out), 32'(free));
    chk({tag, "_full"},  32'(bus.Full_out), 32'(full));
    chk({tag, "_afull"}, 32'(bus.Almost_full_out), 32'(afull));
    chk({tag, "_empty"}, 32'(bus.Empty_out), 32'(empty));
  endtask

  task automatic pop_chk(input string tag);
    cycle(2'd0, 8'h00, 8'h00, 1'b1);
    chk({tag, "_valid"}, 32'(bus.Data_valid), 32'd1);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_data: got %0h expected nothing (queue empty)", tag, bus.Data_out);
    end else begin
      chk({tag, "_data"}, 32'(bus.Data_out), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    bus.WriteCnt_in = '0;
    bus.Data_in     = '0;
    bus.ReadEn_in   = 1'b0;

    // reset
    Clear_in = 1'b1;
    cycle(2'd0, 8'h00, 8'h00, 1'b0);
    cycle(2'd0, 8'h00, 8'h00, 1'b0);
    status("rst", 8, 1'b0, 1'b0, 1'b1);
    chk("rst_valid", 32'(bus.Data_valid), 32'd0);
    chk("rst_dout",  32'(bus.Data_out), 32'd0);
    chk("rst_ovf",   32'(bus.Overflow_out), 32'd0);
    chk("rst_udf",   32'(bus.Underflow_out), 32'd0);
    Clear_in = 1'b0;

    // idle after reset
    for (int k = 0; k < 3; k++) begin
      cycle(2'd0, 8'h00, 8'h00, 1'b0);
      status("idle", 8, 1'b0, 1'b0, 1'b1);
      chk("idle_valid", 32'(bus.Data_valid), 32'd0);
    end

    // four double writes fill the FIFO
    wr2(8'h11, 8'h10); status("fill1", 6, 1'b0, 1'b0, 1'b0);
    wr2(8'h13, 8'h12); status("fill2", 4, 1'b0, 1'b0, 1'b0);
    wr2(8'h15, 8'h14); status("fill3", 2, 1'b0, 1'b1, 1'b0);
    wr2(8'h17, 8'h16); status("fill4", 0, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      pop_chk("drain");
      chk("drain_free", 32'(bus.Free_out), 32'(k));
    end
    chk("drain_empty", 32'(bus.Empty_out), 32'd1);
    cycle(2'd0, 8'h00, 8'h00, 1'b0);
    chk("hold_valid", 32'(bus.Data_valid), 32'd0);
    chk("hold_dout",  32'(bus.Data_out), 32'h17);

    // fill to 7, then a double write must be rejected without touching Mem
    wr2(8'h21, 8'h20);
    wr2(8'h23, 8'h22);
    wr2(8'h25, 8'h24);
    cycle(2'd1, 8'h00, 8'h26, 1'b0);
    exp_q.push_back(8'h26);
    status("seven", 1, 1'b1, 1'b1, 1'b0);
    cycle(2'd2, 8'hEE, 8'hDD, 1'b0);
    status("ovf", 1, 1'b1, 1'b1, 1'b0);
    chk("ovf_flag", 32'(bus.Overflow_out), 32'(FLAGS_ON));
    for (int k = 0; k < 7; k++) pop_chk("ovf_drain");
    status("ovf_drained", 8, 1'b0, 1'b0, 1'b1);
    chk("ovf_sticky", 32'(bus.Overflow_out), 32'(FLAGS_ON));

    // pointers now at 7: this write splits across Mem[7] and Mem[0]
    wr2(8'h22, 8'h11);
    status("wrap", 6, 1'b0, 1'b0, 1'b0);
    pop_chk("wrap_a");
    pop_chk("wrap_b");

    // simultaneous pop and double write with one entry held
    cycle(2'd1, 8'h00, 8'h33, 1'b0);
    exp_q.push_back(8'h33);
    chk("one_free", 32'(bus.Free_out), 32'd7);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h55);
    cycle(2'd2, 8'h55, 8'h44, 1'b1);
    chk("both_valid", 32'(bus.Data_valid), 32'd1);
    chk("both_data",  32'(bus.Data_out), 32'(exp_q.pop_front()));
    status("both", 6, 1'b0, 1'b0, 1'b0);
    pop_chk("both_a");
    pop_chk("both_b");
    chk("pre_udf", 32'(bus.Underflow_out), 32'd0);

    // pop while empty with a same-cycle write: no bypass
    cycle(2'd1, 8'h00, 8'h66, 1'b1);
    exp_q.push_back(8'h66);
    chk("udf_valid", 32'(bus.Data_valid), 32'd0);
    status("udf", 7, 1'b0, 1'b0, 1'b0);
    chk("udf_flag", 32'(bus.Underflow_out), 32'(FLAGS_ON));
    pop_chk("udf_pop");
    chk("udf_free", 32'(bus.Free_out), 32'd8);

    // count above WR_PORTS is rejected even with room
    cycle(2'd3, 8'h77, 8'h77, 1'b0);
    status("cnt3", 8, 1'b0, 1'b0, 1'b1);

    // reset mid-operation discards contents and the pending pop
    wr2(8'h89, 8'h88);
    chk("pre_clr_free", 32'(bus.Free_out), 32'd6);
    Clear_in = 1'b1;
    cycle(2'd0, 8'h00, 8'h00, 1'b1);
    Clear_in = 1'b0;
    exp_q.delete();
    status("clr", 8, 1'b0, 1'b0, 1'b1);
    chk("clr_valid", 32'(bus.Data_valid), 32'd0);
    chk("clr_dout",  32'(bus.Data_out), 32'd0);
    chk("clr_ovf",   32'(bus.Overflow_out), 32'd0);
    chk("clr_udf",   32'(bus.Underflow_out), 32'd0);
    cycle(2'd0, 8'h00, 8'h00, 1'b1);
    chk("post_clr_valid", 32'(bus.Data_valid), 32'd0);
    chk("post_clr_empty", 32'(bus.Empty_out), 32'd1);
    chk("post_clr_udf",   32'(bus.Underflow_out), 32'(FLAGS_ON));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
